// File: rtl/rx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_pkg -- shared codes, state encoding and byte-enable helper for RX delimit
// Revision 1.0
// ---------------------------------------------------------------------------
package rx_pkg;

  localparam logic [7:0] START     = 8'hdf;
  localparam logic [7:0] PREAMBLE  = 8'h55;
  localparam logic [7:0] SFD       = 8'hd5;
  localparam logic [7:0] TERMINATE = 8'hfd;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  // Lanes strictly below k are enabled (k=0 -> none).
  function automatic logic [7:0] therm_be(input logic [2:0] k);
    logic [7:0] be;
    be = 8'h00;
    for (int i = 0; i < 8; i++) begin
      be[i] = (i < int'(k));
    end
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_term_find.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_term_find -- locates a terminate code and flags stray control bytes
// Revision 1.0
// ---------------------------------------------------------------------------
module rx_term_find
  import rx_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [7:0]  ctrl_i,
  output logic        term_o,
  output logic [2:0]  lane_o,
  output logic        illegal_o
);

  logic seen_ctl;

  // A terminate only counts if every lane below it is plain data.
  always_comb begin
    term_o   = 1'b0;
    lane_o   = 3'd0;
    seen_ctl = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!term_o && !seen_ctl && ctrl_i[k] && (data_i[8*k +: 8] == TERMINATE)) begin
        term_o = 1'b1;
        lane_o = 3'(k);
      end
      seen_ctl = seen_ctl | ctrl_i[k];
    end
    illegal_o = (|ctrl_i) & ~term_o;
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_delimit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_frame_delimit -- strips start/preamble/SFD, emits payload with SOP/EOP/err
// Revision 1.0
// ---------------------------------------------------------------------------
module rx_frame_delimit
  import rx_pkg::*;
(
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc8,
  input  logic        link_fault,
  output logic [63:0] rx_data,
  output logic [7:0]  rx_be,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_err,
  output logic [15:0] preamble_err_cnt
);

  state_e      state_q, state_d;
  logic        first_q, first_d;
  logic        err_q, err_d;
  logic [63:0] buf_q, buf_d;
  logic        full_q, full_d;
  logic        flush_q, flush_d;
  logic [7:0]  flush_be_q, flush_be_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  be_q, be_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        oerr_q, oerr_d;

  logic        term_hit;
  logic [2:0]  term_lane;
  logic        illegal;
  logic        start_ctl;
  logic        start_ok;
  logic [15:0] cnt_inc;

  rx_term_find u_term_find (
    .data_i    (rxd64),
    .ctrl_i    (rxc8),
    .term_o    (term_hit),
    .lane_o    (term_lane),
    .illegal_o (illegal)
  );

  assign start_ctl = rxc8[0] && (rxd64[7:0] == START);
  assign start_ok  = start_ctl && (rxc8[7:1] == 7'h00)
                     && (rxd64[55:8] == {6{PREAMBLE}})
                     && (rxd64[63:56] == SFD);
  assign cnt_inc   = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    err_d      = err_q;
    buf_d      = buf_q;
    full_d     = full_q;
    flush_d    = 1'b0;
    flush_be_d = flush_be_q;
    cnt_d      = cnt_q;
    data_d     = 64'h0;
    be_d       = 8'h00;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    oerr_d     = 1'b0;

    // Final partial word left behind by a terminate in lane 1..7.
    if (flush_q) begin
      data_d  = buf_q;
      be_d    = flush_be_q;
      valid_d = 1'b1;
      sop_d   = first_q;
      eop_d   = 1'b1;
      oerr_d  = err_q;
      full_d  = 1'b0;
      first_d = 1'b0;
      err_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_ctl) begin
          if (start_ok) begin
            state_d = ST_DATA;
            first_d = 1'b1;
            err_d   = 1'b0;
            full_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_DATA: begin
        if (start_ctl) begin
          // Truncated frame: close what we hold as bad, then reparse the start.
          if (full_q) begin
            data_d  = buf_q;
            be_d    = 8'hff;
            valid_d = 1'b1;
            sop_d   = first_q;
            eop_d   = 1'b1;
            oerr_d  = 1'b1;
          end
          full_d  = 1'b0;
          first_d = 1'b1;
          err_d   = 1'b0;
          if (!start_ok) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_inc;
          end
        end else if (term_hit) begin
          state_d = ST_IDLE;
          if (term_lane == 3'd0) begin
            if (full_q) begin
              data_d  = buf_q;
              be_d    = 8'hff;
              valid_d = 1'b1;
              sop_d   = first_q;
              eop_d   = 1'b1;
              oerr_d  = err_q | link_fault;
            end
            full_d  = 1'b0;
            first_d = 1'b0;
            err_d   = 1'b0;
          end else begin
            if (full_q) begin
              data_d  = buf_q;
              be_d    = 8'hff;
              valid_d = 1'b1;
              sop_d   = first_q;
            end
            buf_d      = rxd64;
            full_d     = 1'b1;
            flush_d    = 1'b1;
            flush_be_d = therm_be(term_lane);
            first_d    = first_q & ~full_q;
            err_d      = err_q | link_fault;
          end
        end else begin
          if (full_q) begin
            data_d  = buf_q;
            be_d    = 8'hff;
            valid_d = 1'b1;
            sop_d   = first_q;
          end
          buf_d   = rxd64;
          full_d  = 1'b1;
          first_d = first_q & ~full_q;
          err_d   = err_q | illegal | link_fault;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      buf_q      <= 64'h0;
      full_q     <= 1'b0;
      flush_q    <= 1'b0;
      flush_be_q <= 8'h00;
      cnt_q      <= 16'h0000;
      data_q     <= 64'h0;
      be_q       <= 8'h00;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      err_q      <= err_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      flush_q    <= flush_d;
      flush_be_q <= flush_be_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      be_q       <= be_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      oerr_q     <= oerr_d;
    end
  end

  assign rx_data          = data_q;
  assign rx_be            = be_q;
  assign rx_valid         = valid_q;
  assign rx_sop           = sop_q;
  assign rx_eop           = eop_q;
  assign rx_err           = oerr_q;
  assign preamble_err_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_delimit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rx_frame_delimit -- directed scoreboard bench for rx_frame_delimit
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_rx_frame_delimit;

  localparam logic [63:0] START_W = 64'hd555_5555_5555_55df;
  localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rxd64 = IDLE_W;
  logic [7:0]  rxc8 = 8'hff;
  logic        link_fault = 1'b0;
  logic [63:0] rx_data;
  logic [7:0]  rx_be;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic [15:0] preamble_err_cnt;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;

  rx_frame_delimit dut (
    .rxclk            (rxclk),
    .reset            (reset),
    .rxd64            (rxd64),
    .rxc8             (rxc8),
    .link_fault       (link_fault),
    .rx_data          (rx_data),
    .rx_be            (rx_be),
    .rx_valid         (rx_valid),
    .rx_sop           (rx_sop),
    .rx_eop           (rx_eop),
    .rx_err           (rx_err),
    .preamble_err_cnt (preamble_err_cnt)
  );

  always #5 rxclk = ~rxclk;
  always @(posedge rxclk) cyc_n <= cyc_n + 1;

  function automatic logic [7:0] tb_be(input int k);
    return (8'h01 << k) - 8'h01;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{be[l]}};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The word driven now is sampled at the next edge and must appear one edge later.
  task automatic push(input logic [63:0] d, input logic [7:0] be,
                      input logic sop, input logic eop, input logic err);
    exp_t e;
    e.data = d & lane_mask(be);
    e.be   = be;
    e.sop  = sop;
    e.eop  = eop;
    e.err  = err;
    e.cyc  = cyc_n + 2;
    sb.push_back(e);
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] c, input logic f);
    rxd64      = d;
    rxc8       = c;
    link_fault = f;
    @(posedge rxclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(IDLE_W, 8'hff, 1'b0);
  endtask

  // n payload words then terminate in lane k; word 'bad' carries /E/ or a fault pulse.
  task automatic frame(input int n, input int k, input int bad, input logic fault);
    logic [63:0] d;
    logic [63:0] t;
    logic [7:0]  c;
    logic [7:0]  tc;
    logic        f;
    send(START_W, 8'h01, 1'b0);
    for (int j = 0; j < n; j++) begin
      d = {$urandom, $urandom};
      c = 8'h00;
      f = 1'b0;
      if (j == bad) begin
        if (fault) f = 1'b1;
        else begin
          d[31:24] = 8'hfe;
          c        = 8'h08;
        end
      end
      push(d, 8'hff, j == 0, (k == 0) && (j == n - 1), (k == 0) && (j == n - 1) && (bad >= 0));
      send(d, c, f);
    end
    t  = IDLE_W;
    tc = 8'hff << k;
    for (int l = 0; l < k; l++) t[8*l +: 8] = 8'($urandom);
    t[8*k +: 8] = 8'hfd;
    if (k > 0) push(t, tb_be(k), n == 0, 1'b1, bad >= 0);
    send(t, tc, 1'b0);
  endtask

  always @(negedge rxclk) begin : mon
    exp_t e;
    logic ev;
    ev = (sb.size() > 0) && (sb[0].cyc == cyc_n);
    chk("rx_valid", 64'(rx_valid), 64'(ev));
    if (ev) begin
      e = sb.pop_front();
      chk("rx_data", rx_data & lane_mask(e.be), e.data);
      chk("rx_be", 64'(rx_be), 64'(e.be));
      chk("rx_sop", 64'(rx_sop), 64'(e.sop));
      chk("rx_eop", 64'(rx_eop), 64'(e.eop));
      if (e.eop) chk("rx_err", 64'(rx_err), 64'(e.err));
    end
  end

  initial begin
    logic [63:0] d;
    repeat (3) @(posedge rxclk);
    #1;
    chk("reset_valid", 64'(rx_valid), 64'd0);
    chk("reset_sop", 64'(rx_sop), 64'd0);
    chk("reset_eop", 64'(rx_eop), 64'd0);
    chk("reset_err", 64'(rx_err), 64'd0);
    chk("reset_be", 64'(rx_be), 64'd0);
    chk("reset_data", rx_data, 64'd0);
    chk("reset_cnt", 64'(preamble_err_cnt), 64'd0);
    reset = 1'b0;
    idle(2);

    frame(8, 0, -1, 1'b0);
    idle(3);

    // Partial last word, whose flush coincides with a bad-SFD start word.
    frame(8, 5, -1, 1'b0);
    send(64'hd455_5555_5555_55df, 8'h01, 1'b0);
    chk("cnt_bad_sfd", 64'(preamble_err_cnt), 64'd1);
    idle(1);
    frame(8, 0, -1, 1'b0);
    idle(2);

    send(64'hd555_5555_5455_55df, 8'h01, 1'b0);
    chk("cnt_bad_pre", 64'(preamble_err_cnt), 64'd2);
    idle(2);

    frame(8, 0, 3, 1'b0);
    idle(2);

    // Second start after three data words truncates the first frame.
    send(START_W, 8'h01, 1'b0);
    for (int j = 0; j < 3; j++) begin
      d = {$urandom, $urandom};
      push(d, 8'hff, j == 0, j == 2, j == 2);
      send(d, 8'h00, 1'b0);
    end
    frame(4, 0, -1, 1'b0);
    idle(2);

    frame(6, 2, 2, 1'b1);
    idle(2);

    frame(1, 0, -1, 1'b0);
    frame(0, 3, -1, 1'b0);
    frame(0, 0, -1, 1'b0);
    idle(3);
    chk("cnt_hold", 64'(preamble_err_cnt), 64'd2);

    // Reset mid-frame: the word still in the buffer is dropped, no EOP.
    send(START_W, 8'h01, 1'b0);
    for (int j = 0; j < 3; j++) begin
      d = {$urandom, $urandom};
      if (j < 2) push(d, 8'hff, j == 0, 1'b0, 1'b0);
      send(d, 8'h00, 1'b0);
    end
    reset = 1'b1;
    send({$urandom, $urandom}, 8'h00, 1'b0);
    chk("rst_mid_valid", 64'(rx_valid), 64'd0);
    chk("rst_mid_eop", 64'(rx_eop), 64'd0);
    chk("rst_mid_cnt", 64'(preamble_err_cnt), 64'd0);
    reset = 1'b0;
    idle(3);
    frame(2, 0, -1, 1'b0);
    idle(4);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
